// File: rtl/comp_accum.sv
// Streaming signed frame accumulator: sums N_SAMPLES 8-bit samples with
// saturation, tracks min/max, and holds each result until it is taken.
module comp_accum #(
  parameter int N_SAMPLES = 8,
  parameter int SUM_W     = 12,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [7:0]       out_min,
  output logic [7:0]       out_max,
  output logic             out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [SUM_W-1:0] POS_LIM =
    {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] NEG_LIM =
    {1'b1, {(SUM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;
  logic [SUM_W-1:0] osum_q, osum_d;
  logic [7:0]       omin_q, omin_d;
  logic [7:0]       omax_q, omax_d;
  logic             oovf_q, oovf_d;

  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_sat;
  logic             sat;
  logic [7:0]       min_new;
  logic [7:0]       max_new;

  // One guard bit: top two bits disagree exactly when the add left range.
  assign sum_ext = {acc_q[SUM_W-1], acc_q}
                 + {{(SUM_W-7){in_data[7]}}, in_data};

  always_comb begin
    sat     = 1'b0;
    sum_sat = sum_ext[SUM_W-1:0];
    if (!sum_ext[SUM_W] && sum_ext[SUM_W-1]) begin
      sat     = 1'b1;
      sum_sat = POS_LIM;
    end else if (sum_ext[SUM_W] && !sum_ext[SUM_W-1]) begin
      sat     = 1'b1;
      sum_sat = NEG_LIM;
    end
  end

  assign min_new = ($signed(in_data) < $signed(min_q))
                 ? in_data : min_q;
  assign max_new = ($signed(in_data) > $signed(max_q))
                 ? in_data : max_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    min_d   = min_q;
    max_d   = max_q;
    osum_d  = osum_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    oovf_d  = oovf_q;
    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sum_sat;
          ovf_d = ovf_q | sat;
          min_d = min_new;
          max_d = max_new;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = HOLD;
            osum_d  = sum_sat;
            omin_d  = min_new;
            omax_d  = max_new;
            oovf_d  = ovf_q | sat;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          cnt_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          min_d   = 8'h7F;
          max_d   = 8'h80;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      min_q   <= 8'h7F;
      max_q   <= 8'h80;
      osum_q  <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      min_q   <= min_d;
      max_q   <= max_d;
      osum_q  <= osum_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      oovf_q  <= oovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = osum_q;
  assign out_min   = omin_q;
  assign out_max   = omax_q;
  assign out_ovf   = oovf_q;

endmodule
